// File: rtl/scan_bist_pkg.sv
// Shared types, polynomial taps and step functions for the scan/c17 BIST sequencer.
package scan_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int unsigned POLY_W       = 16;
    localparam int unsigned PI_W         = 5;
    localparam int unsigned RESP_W       = 3;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] MISR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Fibonacci step: feedback from bits 15,13,12,10 enters at bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

    // data is the current signature, w the word folded in this cycle.
    function automatic logic [15:0] misr_step(input logic [15:0] data, input logic [15:0] w);
        return {data[14:0], ^(data & MISR_TAPS)} ^ w;
    endfunction

endpackage

// File: rtl/scan_bist_misr.sv
// 16-bit multiple-input signature register with synchronous clear and enable.
module scan_bist_misr
    import scan_bist_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] data,
    output logic [15:0] sig,
    output logic [15:0] sig_nxt_c
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;

    assign sig_nxt_c = misr_step(sig_q, data);

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = sig_nxt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/scan_bist_ctrl.sv
// BIST sequencer: LFSR-fed shift register + c17 patterns compacted into a MISR.
// Optional SCAN_ABORT_EN adds an abort input that returns a running test to IDLE.
module scan_bist_ctrl
    import scan_bist_pkg::*;
#(
    parameter int unsigned SREG_W  = 8,
    parameter int unsigned NUM_PAT = 16,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter logic [15:0] GOLDEN  = 16'h0000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
`ifdef SCAN_ABORT_EN
    input  logic                             abort,
`endif
    input  logic [SREG_W-1:0]                sreg_q,
    input  logic [2:0]                       resp,
    output logic                             sreg_rst,
    output logic                             sreg_sin,
    output logic [4:0]                       pi,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [15:0]                      signature,
    output logic [$clog2(NUM_PAT+1)-1:0]     pat_idx
);

    localparam int unsigned PAT_W    = $clog2(NUM_PAT + 1);
    localparam int unsigned BIT_W    = (SREG_W > 1) ? $clog2(SREG_W) : 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SREG_W - 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PAT - 1);

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [PAT_W-1:0]   pat_idx_q, pat_idx_d;
    logic [4:0]         pi_q, pi_d;
    logic               sreg_rst_q, sreg_rst_d;
    logic               sreg_sin_q, sreg_sin_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               misr_clr_c;
    logic               misr_en_c;
    logic               abort_c;
    logic [15:0]        cap_word_c;
    logic [15:0]        misr_sig;
    logic [15:0]        misr_nxt_c;

`ifdef SCAN_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    assign cap_word_c = 16'({sreg_q, resp});

    scan_bist_misr u_misr (
        .clk       (clk),
        .reset     (reset),
        .clr       (misr_clr_c),
        .en        (misr_en_c),
        .data      (cap_word_c),
        .sig       (misr_sig),
        .sig_nxt_c (misr_nxt_c)
    );

    // Next state, counters and LFSR; outputs are registered from the next state.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        lfsr_d     = lfsr_q;
        pat_idx_d  = pat_idx_q;
        pi_d       = pi_q;
        pass_d     = pass_q;
        misr_clr_c = 1'b0;
        misr_en_c  = 1'b0;
        sreg_rst_d = 1'b0;
        sreg_sin_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                lfsr_d     = SEED_EFF;
                misr_clr_c = 1'b1;
                pat_idx_d  = '0;
                bit_cnt_d  = '0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (bit_cnt_q == '0) begin
                    pi_d = lfsr_q[15:11];
                end
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = CAPTURE;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            CAPTURE: begin
                misr_en_c = 1'b1;
                pat_idx_d = pat_idx_q + PAT_W'(1);
                if (pat_idx_q == PAT_LAST) begin
                    state_d = DONE;
                    pass_d  = (misr_nxt_c == GOLDEN);
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort leaves signature and pattern count exactly as they were.
        if (abort_c && (state_q == CLEAR || state_q == SHIFT || state_q == CAPTURE)) begin
            state_d    = IDLE;
            misr_clr_c = 1'b0;
            misr_en_c  = 1'b0;
            pat_idx_d  = pat_idx_q;
            lfsr_d     = lfsr_q;
            bit_cnt_d  = '0;
        end

        sreg_rst_d = (state_d == CLEAR);
        sreg_sin_d = (state_d == SHIFT) ? lfsr_d[0] : 1'b0;
        busy_d     = (state_d == CLEAR) || (state_d == SHIFT) || (state_d == CAPTURE);
        done_d     = (state_d == DONE);
        if (state_d == IDLE) begin
            pi_d   = '0;
            pass_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            lfsr_q     <= SEED_EFF;
            pat_idx_q  <= '0;
            pi_q       <= '0;
            sreg_rst_q <= 1'b0;
            sreg_sin_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            lfsr_q     <= lfsr_d;
            pat_idx_q  <= pat_idx_d;
            pi_q       <= pi_d;
            sreg_rst_q <= sreg_rst_d;
            sreg_sin_q <= sreg_sin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign sreg_rst  = sreg_rst_q;
    assign sreg_sin  = sreg_sin_q;
    assign pi        = pi_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_sig;
    assign pat_idx   = pat_idx_q;

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Self-checking bench for scan_bist_ctrl: shift register + c17 environment model,
// per-cycle table for a tiny configuration, and randomized MISR inputs.
module tb_scan_bist_ctrl;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] misr_adv(input logic [15:0] m, input logic [15:0] d);
        return lfsr_adv(m) ^ d;
    endfunction

    // c17 netlist; the third response bit is modelled as N22^N23.
    function automatic logic [2:0] c17(input logic [4:0] p);
        logic n1, n2, n3, n6, n7, n10, n11, n16, n19, n22, n23;
        n1 = p[4]; n2 = p[3]; n3 = p[2]; n6 = p[1]; n7 = p[0];
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        n22 = ~(n10 & n16);
        n23 = ~(n16 & n19);
        return {n22 ^ n23, n23, n22};
    endfunction

    // Whole-run signature: each pattern shifts w LFSR bits, then folds {sreg, c17(pi)}.
    function automatic logic [15:0] model_sig(input int w, input int n, input logic [15:0] seed);
        logic [15:0] lf, m, sr, d, mask;
        logic [4:0]  p;
        lf   = (seed == 16'h0000) ? 16'hACE1 : seed;
        m    = 16'h0000;
        sr   = 16'h0000;
        mask = 16'((32'd1 << w) - 32'd1);
        for (int i = 0; i < n; i++) begin
            p = lf[15:11];
            for (int b = 0; b < w; b++) begin
                sr = {sr[14:0], lf[0]};
                lf = lfsr_adv(lf);
            end
            d = ((sr & mask) << 3) | {13'd0, c17(p)};
            m = misr_adv(m, d);
        end
        return m;
    endfunction

    localparam logic [15:0] MODEL_SIG = model_sig(8, 16, 16'hACE1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Main instance (passing golden) and a twin with a wrong golden, same stimulus.
    logic        rst, start;
`ifdef SCAN_ABORT_EN
    logic        abort;
`endif
    logic [7:0]  env_sreg;
    logic [2:0]  env_resp;
    logic        m_sreg_rst, m_sreg_sin, m_busy, m_done, m_pass;
    logic [4:0]  m_pi, m_idx;
    logic [15:0] m_sig;
    logic        b_sreg_rst, b_sreg_sin, b_busy, b_done, b_pass;
    logic [4:0]  b_pi, b_idx;
    logic [15:0] b_sig;

    always_ff @(posedge clk) begin
        if (rst || m_sreg_rst) env_sreg <= '0;
        else                   env_sreg <= {env_sreg[6:0], m_sreg_sin};
    end
    always_comb env_resp = c17(m_pi);

    scan_bist_ctrl #(.SREG_W(8), .NUM_PAT(16), .SEED(16'hACE1), .GOLDEN(MODEL_SIG)) u_main (
        .clk(clk), .reset(rst), .start(start),
`ifdef SCAN_ABORT_EN
        .abort(abort),
`endif
        .sreg_q(env_sreg), .resp(env_resp), .sreg_rst(m_sreg_rst), .sreg_sin(m_sreg_sin),
        .pi(m_pi), .busy(m_busy), .done(m_done), .pass(m_pass), .signature(m_sig), .pat_idx(m_idx)
    );

    scan_bist_ctrl #(.SREG_W(8), .NUM_PAT(16), .SEED(16'hACE1), .GOLDEN(MODEL_SIG ^ 16'h0001)) u_bad (
        .clk(clk), .reset(rst), .start(start),
`ifdef SCAN_ABORT_EN
        .abort(abort),
`endif
        .sreg_q(env_sreg), .resp(env_resp), .sreg_rst(b_sreg_rst), .sreg_sin(b_sreg_sin),
        .pi(b_pi), .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .pat_idx(b_idx)
    );

    // Tiny configuration with forced responses.
    logic        s_rst, s_start;
    logic        s_sreg_rst, s_sreg_sin, s_busy, s_done, s_pass;
    logic [4:0]  s_pi;
    logic [0:0]  s_idx;
    logic [15:0] s_sig;

    scan_bist_ctrl #(.SREG_W(4), .NUM_PAT(1)) u_small (
        .clk(clk), .reset(s_rst), .start(s_start),
`ifdef SCAN_ABORT_EN
        .abort(1'b0),
`endif
        .sreg_q(4'hF), .resp(3'b111), .sreg_rst(s_sreg_rst), .sreg_sin(s_sreg_sin),
        .pi(s_pi), .busy(s_busy), .done(s_done), .pass(s_pass), .signature(s_sig), .pat_idx(s_idx)
    );

    // Random-input configuration, seed 0 selects the default seed.
    logic        r_rst, r_start;
    logic [4:0]  r_sq;
    logic [2:0]  r_resp;
    logic        r_sreg_rst, r_sreg_sin, r_busy, r_done, r_pass;
    logic [4:0]  r_pi;
    logic [1:0]  r_idx;
    logic [15:0] r_sig;

    scan_bist_ctrl #(.SREG_W(5), .NUM_PAT(3), .SEED(16'h0000)) u_rnd (
        .clk(clk), .reset(r_rst), .start(r_start),
`ifdef SCAN_ABORT_EN
        .abort(1'b0),
`endif
        .sreg_q(r_sq), .resp(r_resp), .sreg_rst(r_sreg_rst), .sreg_sin(r_sreg_sin),
        .pi(r_pi), .busy(r_busy), .done(r_done), .pass(r_pass), .signature(r_sig), .pat_idx(r_idx)
    );

    typedef struct {
        logic        start;
        logic        rst_o;
        logic        sin;
        logic        busy;
        logic        done;
        logic        pass;
        logic [4:0]  pi;
        logic [15:0] sig;
        logic        idx;
    } vec_t;

    function automatic vec_t mkv(input logic st, input logic ro, input logic si, input logic bu,
                                 input logic dn, input logic pa, input logic [4:0] p,
                                 input logic [15:0] sg, input logic ix);
        vec_t v;
        v.start = st; v.rst_o = ro; v.sin = si; v.busy = bu; v.done = dn;
        v.pass = pa; v.pi = p; v.sig = sg; v.idx = ix;
        return v;
    endfunction

    function automatic logic [31:0] main_pack();
        return 32'({m_sreg_rst, m_sreg_sin, m_pi, m_busy, m_done, m_pass, m_sig, m_idx});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [10];
        logic [15:0] lf;
        logic [15:0] rm;
        logic [15:0] d;
        int          done_edge;

        tbl[0] = mkv(1, 1, 0, 1, 0, 0, 5'h00, 16'h0000, 1'b0);
        tbl[1] = mkv(1, 0, 1, 1, 0, 0, 5'h00, 16'h0000, 1'b0);
        tbl[2] = mkv(0, 0, 1, 1, 0, 0, 5'h15, 16'h0000, 1'b0);
        tbl[3] = mkv(1, 0, 1, 1, 0, 0, 5'h15, 16'h0000, 1'b0);
        tbl[4] = mkv(0, 0, 1, 1, 0, 0, 5'h15, 16'h0000, 1'b0);
        tbl[5] = mkv(0, 0, 0, 1, 0, 0, 5'h15, 16'h0000, 1'b0);
        tbl[6] = mkv(1, 0, 0, 0, 1, 0, 5'h15, 16'h007F, 1'b1);
        tbl[7] = mkv(1, 0, 0, 0, 1, 0, 5'h15, 16'h007F, 1'b1);
        tbl[8] = mkv(0, 0, 0, 0, 0, 0, 5'h00, 16'h007F, 1'b1);
        tbl[9] = mkv(0, 0, 0, 0, 0, 0, 5'h00, 16'h007F, 1'b1);

        rst = 1'b1; start = 1'b0;
        s_rst = 1'b1; s_start = 1'b0;
        r_rst = 1'b1; r_start = 1'b0; r_sq = '0; r_resp = '0;
`ifdef SCAN_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_main_outputs", main_pack(), 32'd0);
        check("reset_small_outputs", 32'({s_sreg_rst, s_sreg_sin, s_pi, s_busy, s_done, s_pass, s_sig, s_idx}), 32'd0);
        rst = 1'b0; s_rst = 1'b0; r_rst = 1'b0;

        // Reset in the middle of pattern 3.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        check("midrun_busy", 32'(m_busy), 32'd1);
        check("midrun_pat_idx", 32'(m_idx), 32'd2);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("in_reset_outputs", main_pack(), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_reset_outputs", main_pack(), 32'd0);

        // Full run with a stray start pulse while busy.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lf = 16'hACE1;
        done_edge = 0;
        for (int e = 2; e <= 400 && done_edge == 0; e++) begin
            @(posedge clk); #1;
            if (e == 2) check("first_sin_bit", 32'(m_sreg_sin), 32'd1);
            if (e >= 2 && e <= 9) begin
                check($sformatf("sin_bit%0d", e - 2), 32'(m_sreg_sin), 32'(lf[0]));
                lf = lfsr_adv(lf);
            end
            if (e == 30) start = 1'b1;
            if (e == 31) start = 1'b0;
            if (m_done) done_edge = e;
        end
        check("main_done_edge", 32'(done_edge), 32'd146);
        check("main_pat_idx", 32'(m_idx), 32'd16);
        check("main_signature", 32'(m_sig), 32'(MODEL_SIG));
        check("main_pass", 32'(m_pass), 32'd1);
        check("bad_golden_pass", 32'(b_pass), 32'd0);
        check("bad_golden_done", 32'(b_done), 32'd1);

        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("done_hold%0d", k), 32'({m_done, m_busy}), 32'd2);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("done_exit_flags", 32'({m_done, m_busy, m_pass, m_pi}), 32'd0);
        check("done_exit_signature", 32'(m_sig), 32'(MODEL_SIG));
        check("done_exit_pat_idx", 32'(m_idx), 32'd16);

        // Per-cycle table on the tiny configuration.
        for (int r = 0; r < 10; r++) begin
            s_start = tbl[r].start;
            @(posedge clk); #1;
            check($sformatf("small_row%0d", r),
                  32'({s_sreg_rst, s_sreg_sin, s_busy, s_done, s_pass, s_pi, s_sig, s_idx}),
                  32'({tbl[r].rst_o, tbl[r].sin, tbl[r].busy, tbl[r].done, tbl[r].pass,
                       tbl[r].pi, tbl[r].sig, tbl[r].idx}));
        end

        // Random MISR inputs; captures land on edges 2+p*(SREG_W+1).
        for (int run = 0; run < 3; run++) begin
            rm = 16'h0000;
            done_edge = 0;
            r_start = 1'b1;
            @(posedge clk); #1;
            r_start = 1'b0;
            for (int e = 2; e <= 40; e++) begin
                r_sq   = 5'($urandom);
                r_resp = 3'($urandom);
                d      = 16'({r_sq, r_resp});
                @(posedge clk); #1;
                if (e == 2) check($sformatf("rnd%0d_first_sin", run), 32'(r_sreg_sin), 32'd1);
                if (e > 2 && e <= 20 && ((e - 2) % 6) == 0) rm = misr_adv(rm, d);
                if (r_done && done_edge == 0) done_edge = e;
            end
            check($sformatf("rnd%0d_done_edge", run), 32'(done_edge), 32'd20);
            check($sformatf("rnd%0d_signature", run), 32'(r_sig), 32'(rm));
            check($sformatf("rnd%0d_pat_idx", run), 32'(r_idx), 32'd3);
        end

`ifdef SCAN_ABORT_EN
        // Abort during CAPTURE of pattern 5, then a clean full run.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_flags", 32'({m_busy, m_done, m_pass, m_sreg_sin}), 32'd0);
        check("abort_pat_idx", 32'(m_idx), 32'd4);
        check("abort_signature", 32'(m_sig), 32'(model_sig(8, 4, 16'hACE1)));
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", 32'({m_busy, m_done}), 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_edge = 0;
        for (int e = 2; e <= 400 && done_edge == 0; e++) begin
            @(posedge clk); #1;
            if (m_done) done_edge = e;
        end
        check("rerun_done_edge", 32'(done_edge), 32'd146);
        check("rerun_signature", 32'(m_sig), 32'(MODEL_SIG));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
